// File: rtl/fir_output_scaler.sv
// fir_output_scaler
//
// Output stage of the 8x8 M9K FIR engine. It captures the 36-bit signed
// accumulator on each doneIn pulse and rounds it (round-half-toward-+inf). It
// then arithmetically shifts the value right by SHIFT and saturates it to an
// OUT_WIDTH signed sample. The sample is queued in a FIFO that drains through a
// valid/ready handshake.
//
// Pipeline: capture register -> round/shift register -> saturate + FIFO write.
// A doneIn in cycle N shows up at the FIFO head in cycle N+3 when the FIFO is
// empty.
//
// Optional feature (macro FIR_OUTPUT_SCALER_SAT_COUNT_EN):
//   defined   - satCountOut counts saturated samples and sticks at 0xFFFF.
//   undefined - no counter is built and satCountOut is tied to 0.
//
// Ports:
//   clkIn       - system clock, rising edge
//   nResetIn    - asynchronous active-low reset
//   doneIn      - one-cycle pulse, dataIn valid
//   dataIn      - 36-bit signed accumulator
//   clearIn     - synchronous flush of pipeline, FIFO, flags and counter
//   validOut    - FIFO head holds a sample
//   readyIn     - sink accepts the head when validOut && readyIn
//   dataOut     - FIFO head sample; holds the last head while validOut=0
//   fullOut     - FIFO holds FIFO_DEPTH entries
//   satOut      - sticky: a sample was clipped
//   droppedOut  - sticky: a sample was lost to a full FIFO
//   satCountOut - saturation event count (0 when the feature is disabled)

module fir_output_scaler #(
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clkIn,
  input  logic                 nResetIn,
  input  logic                 doneIn,
  input  logic [35:0]          dataIn,
  input  logic                 clearIn,
  output logic                 validOut,
  input  logic                 readyIn,
  output logic [OUT_WIDTH-1:0] dataOut,
  output logic                 fullOut,
  output logic                 satOut,
  output logic                 droppedOut,
  output logic [15:0]          satCountOut
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned RoundBit = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [36:0] RoundConst = (SHIFT > 0) ? (37'sd1 <<< RoundBit) : 37'sd0;
  localparam logic signed [36:0] SatMax     = (37'sd1 <<< (OUT_WIDTH - 1)) - 37'sd1;
  localparam logic signed [36:0] SatMin     = -(37'sd1 <<< (OUT_WIDTH - 1));

  localparam logic [OUT_WIDTH-1:0] PosClip  = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NegClip  = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [PtrW:0]        DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: capture, stage 2: round and shift
  // ---------------------------------------------------------------------------
  logic                v1Q;
  logic [35:0]         d1Q;
  logic                v2Q;
  logic signed [36:0]  r2Q;
  logic signed [36:0]  extended;
  logic signed [36:0]  biased;
  logic signed [36:0]  roundedD;

  always_comb begin
    extended = {d1Q[35], d1Q};
    // 37 bits hold the 36-bit input plus the rounding bias without overflow
    biased   = extended + RoundConst;
    roundedD = biased >>> SHIFT;
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      v1Q <= 1'b0;
      d1Q <= '0;
      v2Q <= 1'b0;
      r2Q <= '0;
    end else if (clearIn) begin
      v1Q <= 1'b0;
      v2Q <= 1'b0;
    end else begin
      v1Q <= doneIn;
      if (doneIn) begin
        d1Q <= dataIn;
      end
      v2Q <= v1Q;
      if (v1Q) begin
        r2Q <= roundedD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: saturate (combinational, feeds the FIFO write port)
  // ---------------------------------------------------------------------------
  logic                 clipHi;
  logic                 clipLo;
  logic                 clip;
  logic [OUT_WIDTH-1:0] sample;

  always_comb begin
    clipHi = (r2Q > SatMax);
    clipLo = (r2Q < SatMin);
    clip   = clipHi | clipLo;
    if (clipHi) begin
      sample = PosClip;
    end else if (clipLo) begin
      sample = NegClip;
    end else begin
      sample = r2Q[OUT_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wrPtrQ, wrPtrD;
  logic [PtrW-1:0]      rdPtrQ, rdPtrD;
  logic [PtrW:0]        countQ, countD;
  logic [OUT_WIDTH-1:0] headQ, headD;
  logic                 isFull;
  logic                 popAcc;
  logic                 pushAcc;
  logic                 drop;
  logic                 satEvent;

  assign isFull   = (countQ == DepthCnt);
  assign popAcc   = (countQ != '0) && readyIn && !clearIn;
  assign pushAcc  = v2Q && !clearIn && (!isFull || popAcc);
  assign drop     = v2Q && !clearIn && isFull && !popAcc;
  assign satEvent = v2Q && clip && !clearIn;

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    headD  = headQ;
    if (clearIn) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (pushAcc) begin
        wrPtrD = wrPtrQ + PtrW'(1);
      end
      if (popAcc) begin
        rdPtrD = rdPtrQ + PtrW'(1);
      end
      case ({pushAcc, popAcc})
        2'b10:   countD = countQ + (PtrW + 1)'(1);
        2'b01:   countD = countQ - (PtrW + 1)'(1);
        default: countD = countQ;
      endcase
    end
    // The head is a register so dataOut keeps the last sample once the FIFO
    // drains. If the new head is the slot being written this cycle, it must
    // come from the write data rather than the array.
    if (countD != '0) begin
      if (pushAcc && (rdPtrD == wrPtrQ)) begin
        headD = sample;
      end else begin
        headD = mem[rdPtrD];
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (pushAcc) begin
      mem[wrPtrQ] <= sample;
    end
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      headQ  <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
      headQ  <= headD;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags
  // ---------------------------------------------------------------------------
  logic satQ;
  logic droppedQ;

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      satQ     <= 1'b0;
      droppedQ <= 1'b0;
    end else if (clearIn) begin
      satQ     <= 1'b0;
      droppedQ <= 1'b0;
    end else begin
      if (satEvent) begin
        satQ <= 1'b1;
      end
      if (drop) begin
        droppedQ <= 1'b1;
      end
    end
  end

`ifdef FIR_OUTPUT_SCALER_SAT_COUNT_EN
  logic [15:0] satCountQ;

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      satCountQ <= '0;
    end else if (clearIn) begin
      satCountQ <= '0;
    end else if (satEvent && (satCountQ != 16'hFFFF)) begin
      satCountQ <= satCountQ + 16'd1;
    end
  end

  assign satCountOut = satCountQ;
`else
  assign satCountOut = '0;
`endif

  assign validOut   = (countQ != '0);
  assign fullOut    = isFull;
  assign dataOut    = headQ;
  assign satOut     = satQ;
  assign droppedOut = droppedQ;

endmodule

// File: tb/tb_fir_output_scaler.sv
// Self-checking bench for fir_output_scaler (SHIFT=15, OUT_WIDTH=16, FIFO_DEPTH=4).
// A queue-based reference model runs alongside the DUT and is compared with
// it on every falling edge. Directed sections pin both the DUT and the model
// against hand-computed literals.

module tb_fir_output_scaler;

  localparam int Shift = 15;
  localparam int Depth = 4;

  logic        clkIn = 1'b0;
  logic        nResetIn = 1'b0;
  logic        doneIn = 1'b0;
  logic [35:0] dataIn = '0;
  logic        clearIn = 1'b0;
  logic        readyIn = 1'b0;
  logic        validOut;
  logic [15:0] dataOut;
  logic        fullOut;
  logic        satOut;
  logic        droppedOut;
  logic [15:0] satCountOut;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  fir_output_scaler #(
    .SHIFT      (Shift),
    .OUT_WIDTH  (16),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clkIn       (clkIn),
    .nResetIn    (nResetIn),
    .doneIn      (doneIn),
    .dataIn      (dataIn),
    .clearIn     (clearIn),
    .validOut    (validOut),
    .readyIn     (readyIn),
    .dataOut     (dataOut),
    .fullOut     (fullOut),
    .satOut      (satOut),
    .droppedOut  (droppedOut),
    .satCountOut (satCountOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the sample value is computed from plain integer
  // arithmetic; the pipeline is two pending slots, and the FIFO is a queue.
  // ---------------------------------------------------------------------------
  logic [15:0] mQ[$];
  bit          p1V = 1'b0, p2V = 1'b0;
  logic [35:0] p1D = '0, p2D = '0;
  logic [15:0] mHead = '0;
  bit          mSat = 1'b0, mDrop = 1'b0;
  int          mCnt = 0;

  function automatic logic [15:0] scale(input logic [35:0] raw, output bit clipped);
    longint x;
    longint r;
    x = longint'($signed(raw));
    r = (x + (64'sd1 <<< (Shift - 1))) >>> Shift;
    clipped = 1'b0;
    if (r > 32767) begin
      clipped = 1'b1;
      return 16'h7FFF;
    end else if (r < -32768) begin
      clipped = 1'b1;
      return 16'h8000;
    end
    return r[15:0];
  endfunction

  task automatic modelStep();
    logic [15:0] val;
    bit          clp;
    if (!nResetIn) begin
      mQ.delete();
      p1V = 0; p2V = 0; mHead = '0; mSat = 0; mDrop = 0; mCnt = 0;
    end else if (clearIn) begin
      mQ.delete();
      p1V = 0; p2V = 0; mSat = 0; mDrop = 0; mCnt = 0;
    end else begin
      if (mQ.size() > 0 && readyIn) void'(mQ.pop_front());
      if (p2V) begin
        val = scale(p2D, clp);
        if (clp) begin
          mSat = 1'b1;
`ifdef FIR_OUTPUT_SCALER_SAT_COUNT_EN
          if (mCnt != 65535) mCnt++;
`endif
        end
        if (mQ.size() < Depth) mQ.push_back(val);
        else mDrop = 1'b1;
      end
      p2V = p1V; p2D = p1D;
      p1V = doneIn; p1D = dataIn;
      if (mQ.size() > 0) mHead = mQ[0];
    end
  endtask

  initial begin
    forever begin
      @(posedge clkIn or negedge nResetIn);
      modelStep();
    end
  end

  // Compare process: every falling edge once enabled.
  initial begin
    forever begin
      @(negedge clkIn);
      if (checkEn) begin
        check("cmp_valid", 36'(validOut), 36'(mQ.size() > 0));
        check("cmp_data", 36'(dataOut), 36'(mHead));
        check("cmp_full", 36'(fullOut), 36'(mQ.size() == Depth));
        check("cmp_sat", 36'(satOut), 36'(mSat));
        check("cmp_dropped", 36'(droppedOut), 36'(mDrop));
        check("cmp_satcnt", 36'(satCountOut), 36'(mCnt[15:0]));
      end
    end
  end

  // Pulse doneIn once and return on the falling edge where the sample is at
  // the head (FIFO empty beforehand).
  task automatic sendOne(input logic [35:0] v);
    @(negedge clkIn); doneIn = 1'b1; dataIn = v;
    @(negedge clkIn); doneIn = 1'b0;
    @(negedge clkIn);
    check("latency_not_early", 36'(validOut), 36'd0);
    @(negedge clkIn);
  endtask

  task automatic expHead(input string name, input logic [15:0] exp);
    check({name, "_dut"}, 36'(dataOut), 36'(exp));
    check({name, "_model"}, 36'(mHead), 36'(exp));
  endtask

  task automatic expFlags(input string name, input bit v, input bit f, input bit s, input bit d);
    check({name, "_valid"}, 36'(validOut), 36'(v));
    check({name, "_full"}, 36'(fullOut), 36'(f));
    check({name, "_sat"}, 36'(satOut), 36'(s));
    check({name, "_dropped"}, 36'(droppedOut), 36'(d));
  endtask

  int unsigned expCnt;

  initial begin
    longint v;
    // Reset state
    #12;
    expFlags("reset", 0, 0, 0, 0);
    check("reset_data", 36'(dataOut), 36'd0);
    check("reset_satcnt", 36'(satCountOut), 36'd0);
    @(negedge clkIn);
    nResetIn = 1'b1;
    checkEn  = 1'b1;
    readyIn  = 1'b1;

    // Rounding and saturation boundaries
    sendOne(36'h000004000);
    expFlags("p16384", 1, 0, 0, 0);
    expHead("p16384", 16'h0001);
    sendOne(36'h03FFF8000);
    expHead("max_nosat", 16'h7FFF);
    check("max_nosat_sat", 36'(satOut), 36'd0);
    sendOne(36'h040000000);
    expHead("pos_clip", 16'h7FFF);
    check("pos_clip_sat", 36'(satOut), 36'd1);
`ifdef FIR_OUTPUT_SCALER_SAT_COUNT_EN
    expCnt = 1;
`else
    expCnt = 0;
`endif
    check("pos_clip_cnt", 36'(satCountOut), 36'(expCnt));
    sendOne(36'hFFFFFC000);
    expHead("m16384", 16'h0000);
    sendOne(36'hFFFFFBFFF);
    expHead("m16385", 16'hFFFF);
    sendOne(36'h800000000);
    expHead("neg_clip", 16'h8000);
    check("neg_clip_sat", 36'(satOut), 36'd1);
    @(negedge clkIn);
    check("hold_after_drain_valid", 36'(validOut), 36'd0);
    expHead("hold_after_drain", 16'h8000);

    // Fill with readyIn low, overflow by one
    clearIn = 1'b1; readyIn = 1'b0;
    @(negedge clkIn); clearIn = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      doneIn = 1'b1; dataIn = 36'(k) << 15;
      @(negedge clkIn);
    end
    doneIn = 1'b0;
    @(negedge clkIn);
    expFlags("fill4", 1, 1, 0, 0);
    @(negedge clkIn);
    expFlags("fill5", 1, 1, 0, 1);
    expHead("drain1", 16'd1);
    readyIn = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clkIn);
      expHead("drain_seq", 16'(k));
    end
    @(negedge clkIn);
    expFlags("drained", 0, 0, 0, 1);
    expHead("drained_hold", 16'd4);

    // Push and pop in the same cycle while full
    clearIn = 1'b1; readyIn = 1'b0;
    @(negedge clkIn); clearIn = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      doneIn = 1'b1; dataIn = 36'(k) << 15;
      @(negedge clkIn);
    end
    doneIn = 1'b0;
    @(negedge clkIn);
    @(negedge clkIn);
    expFlags("full_again", 1, 1, 0, 0);
    doneIn = 1'b1; dataIn = 36'd14 << 15;
    @(negedge clkIn); doneIn = 1'b0;
    @(negedge clkIn); readyIn = 1'b1;
    @(negedge clkIn);
    expFlags("pushpop", 1, 1, 0, 0);
    expHead("pushpop_head", 16'd11);
    for (int k = 12; k <= 14; k++) begin
      @(negedge clkIn);
      expHead("pushpop_seq", 16'(k));
    end
    @(negedge clkIn);
    expFlags("pushpop_drained", 0, 0, 0, 0);

    // clearIn with FIFO half full and satOut set; coincident doneIn discarded
    readyIn = 1'b0;
    @(negedge clkIn); doneIn = 1'b1; dataIn = 36'h040000000;
    @(negedge clkIn); dataIn = 36'h000004000;
    @(negedge clkIn); doneIn = 1'b0;
    @(negedge clkIn);
    @(negedge clkIn);
    expFlags("half_full", 1, 0, 1, 0);
    clearIn = 1'b1; doneIn = 1'b1; dataIn = 36'h000004000;
    @(negedge clkIn); clearIn = 1'b0; doneIn = 1'b0;
    expFlags("cleared", 0, 0, 0, 0);
    check("cleared_cnt", 36'(satCountOut), 36'd0);
    repeat (4) @(negedge clkIn);
    check("clear_discards_done", 36'(validOut), 36'd0);

    // Asynchronous reset mid-pipeline
    sendOne(36'h040000000);
    doneIn = 1'b1; dataIn = 36'h000008000;
    @(negedge clkIn); doneIn = 1'b0;
    #2 nResetIn = 1'b0;
    #1;
    expFlags("async_reset", 0, 0, 0, 0);
    check("async_reset_data", 36'(dataOut), 36'd0);
    check("async_reset_cnt", 36'(satCountOut), 36'd0);
    @(negedge clkIn); nResetIn = 1'b1;
    repeat (4) @(negedge clkIn);
    check("reset_discards_pipe", 36'(validOut), 36'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      doneIn  = ($urandom_range(0, 1) == 1);
      readyIn = ($urandom_range(0, 3) != 0);
      clearIn = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 2))
        0: dataIn = {4'($urandom), 32'($urandom)};
        1: begin
          v = longint'($signed(32'($urandom)));
          v = v >>> $urandom_range(0, 14);
          dataIn = v[35:0];
        end
        default: dataIn = 36'($urandom_range(0, 65535)) - 36'd32768;
      endcase
      @(negedge clkIn);
    end
    doneIn = 1'b0; clearIn = 1'b0; readyIn = 1'b1;
    repeat (8) @(negedge clkIn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
